dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the CPU data-access port; it is the slave end of the load/store interface the pipeline drives at its MEM stage.
- Serves word loads and stores from a local word array.
- Each access takes a configurable number of wait cycles, closed by a single-cycle acknowledge.
- busy_o is exported so the pipeline can stall while an access is outstanding.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the array (power of two, >=2).
- LATENCY, 4, cycles from request acceptance to acknowledge (>=1).

Ports:
- clk_i  input  1  clock, all state on rising edge.
- rst_i  input  1  reset; asynchronous, active-high.
- req_i  input  1  access request; held high by the initiator until ack_o.
- we_i  input  1  1 = store, 0 = load; stable while req_i high.
- addr_i  input  32  byte address; stable while req_i high.
- wdata_i  input  32  store data; stable while req_i high.
- ack_o  output  1  one-cycle completion pulse.
- rdata_o  output  32  load result; valid when ack_o=1 for a good load.
- err_o  output  1  qualifies ack_o: access rejected.
- busy_o  output  1  transaction in progress (state != IDLE).

Behaviour:
- Reset values: state IDLE; ack_o=0, err_o=0, rdata_o=0, busy_o=0; internal counter=0. Array contents are not reset.
- Reset asserted mid-transaction aborts it immediately. A store not yet committed is never written. No ack_o is issued for the aborted access.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_i is sampled only in this state.
  - On an edge with req_i=1, latch we_i, addr_i and wdata_i.
  - Check the latched address. Misaligned means addr_i[1:0] != 0. Out of range means addr_i[31:2] >= DEPTH_WORDS.
  - Bad address: go to RESP with err_o=1. The array and rdata_o are not touched.
  - Good address: go to WAIT with counter=LATENCY-1.
- WAIT:
  - Counter nonzero: decrement it at each edge.
  - Counter zero: at that edge, commit the access and go to RESP.
  - Commit for a store: array[addr[31:2]] <= wdata.
  - Commit for a load: rdata_o <= array[addr[31:2]].
- RESP:
  - ack_o=1 for exactly this one cycle.
  - err_o is 1 only for a rejected access, 0 otherwise.
  - Next edge returns to IDLE, clearing ack_o and err_o.
- Latency:
  - Good access accepted at edge E0: ack_o is high in the cycle following edge E0+LATENCY.
  - Rejected access: ack_o is high in the cycle following E0.
- busy_o is combinational from state. It is 1 from the cycle after acceptance through the RESP cycle inclusive.
- rdata_o holds the last good load value. It is unchanged by stores, rejected accesses and idle cycles.
- Input changes while in WAIT or RESP are ignored; the latched copies are used.
- Back-to-back traffic:
  - After RESP the block is in IDLE for at least one cycle.
  - If req_i is still high in that IDLE cycle, a new transaction is accepted. It is the initiator's duty to drop req_i in the ack cycle if it has no further request.
  - Minimum spacing between ack pulses: LATENCY+2 cycles for good accesses, 2 for rejected ones.
- A load following a store to the same word returns the stored value; stores commit before the store's ack.
- Boundaries:
  - Highest legal byte address is (DEPTH_WORDS-1)*4.
  - Address DEPTH_WORDS*4 is rejected.
  - No wrap-around of the address onto the array.

Test Plan:
- Reset check: hold rst_i high for 3 cycles. Require ack_o=0, err_o=0, busy_o=0, rdata_o=0. Release with req_i=0: state stays IDLE.
- Store then load, LATENCY=4: store 0xDEADBEEF to addr 0x10, then load addr 0x10. Require each ack exactly 4 cycles after its accept edge, busy_o=1 throughout, and rdata_o=0xDEADBEEF with err_o=0 on the load ack.
- Misaligned and out-of-range accesses, DEPTH_WORDS=256:
  - Store to 0x12: ack_o=1 and err_o=1 one cycle after accept; a subsequent load of 0x10 returns the prior contents.
  - Load of 0x400: error ack; rdata_o unchanged.
  - Load of 0x3FC: succeeds.
- Reset mid-store: store 0x12345678 to 0x20, assert rst_i while in WAIT with counter=2. Require no ack_o. After release, a load of 0x20 returns the old value (preload 0xCAFEF00D).
- Back-to-back loads, LATENCY=1: hold req_i high across two loads. Require acks spaced exactly 3 cycles apart, correct data on each, and a one-cycle IDLE gap with busy_o=0 between them.
- Input disturbance: during WAIT, change addr_i and wdata_i to garbage. Require the committed store to use the values latched at acceptance.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU load/store port: serves aligned word
// accesses from a local array after a fixed wait, closing each with a one-cycle ack.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state;
  state_t          state_nx;
  logic [CW-1:0]   cnt;
  logic            err_q;
  logic            we_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic [31:0]     mem [DEPTH_WORDS];
  logic            accept;
  logic            commit;

  // Misaligned, or any address bit above the array index set (no wrap-around).
  function automatic logic addr_reject(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> (AW + 2)) != 32'd0);
  endfunction

  assign accept = (state == IDLE) && req_i;
  assign commit = (state == WAIT) && (cnt == '0);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (req_i) state_nx = addr_reject(addr_i) ? RESP : WAIT;
      WAIT: if (cnt == '0) state_nx = RESP;
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      err_q   <= 1'b0;
      rdata_o <= 32'd0;
    end else begin
      state <= state_nx;
      if (accept) begin
        err_q <= addr_reject(addr_i);
        cnt   <= CW'(LATENCY - 1);
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      if (commit && !we_q) rdata_o <= mem[idx_q];
    end
  end

  // Request payload and array contents carry no reset; a store only lands
  // at its commit edge, so an aborted transaction never reaches the array.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      we_q    <= we_i;
      idx_q   <= addr_i[AW+1:2];
      wdata_q <= wdata_i;
    end
    if (commit && we_q && !rst_i) mem[idx_q] <= wdata_q;
  end

  assign ack_o  = (state == RESP);
  assign err_o  = (state == RESP) && err_q;
  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=4 and a LATENCY=1 instance, driven with
// directed and random accesses and compared against a word-array reference model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req4, req1;
  logic        we;
  logic [31:0] addr, wdata;
  logic        ack4, err4, busy4, ack1, err1, busy1;
  logic [31:0] rdata4, rdata1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem_m  [2][256];
  logic [31:0] exp_rd [2];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .req_i(req4), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .ack_o(ack4), .rdata_o(rdata4), .err_o(err4), .busy_o(busy4)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req1), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .ack_o(ack1), .rdata_o(rdata1), .err_o(err1), .busy_o(busy1)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic ack_of(input int s);
    return (s == 1) ? ack1 : ack4;
  endfunction
  function automatic logic err_of(input int s);
    return (s == 1) ? err1 : err4;
  endfunction
  function automatic logic busy_of(input int s);
    return (s == 1) ? busy1 : busy4;
  endfunction
  function automatic logic [31:0] rdata_of(input int s);
    return (s == 1) ? rdata1 : rdata4;
  endfunction

  task automatic set_req(input int s, input logic v);
    if (s == 1) req1 = v; else req4 = v;
  endtask

  // One complete access on instance s, checked against the reference model.
  task automatic access(input int s, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input bit disturb, input string tag);
    int   lat;
    int   cyc;
    logic bad;
    lat = (s == 1) ? 1 : 4;
    bad = (a[1:0] != 2'b00) || (a >= 32'h400);
    @(negedge clk);
    we = w; addr = a; wdata = d;
    set_req(s, 1'b1);
    @(posedge clk); #1;
    cyc = 0;
    while (!ack_of(s) && cyc < 64) begin
      check_val({tag, ".busy"}, 32'(busy_of(s)), 32'd1);
      if (disturb) begin
        addr = $urandom; wdata = $urandom; we = 1'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
    end
    set_req(s, 1'b0);
    if (!bad) begin
      if (w) mem_m[s][a[9:2]] = d;
      else   exp_rd[s] = mem_m[s][a[9:2]];
    end
    check_val({tag, ".lat"},   32'(cyc), bad ? 32'd0 : 32'(lat));
    check_val({tag, ".err"},   32'(err_of(s)), 32'(bad));
    check_val({tag, ".busy"},  32'(busy_of(s)), 32'd1);
    check_val({tag, ".rdata"}, rdata_of(s), exp_rd[s]);
    @(posedge clk); #1;
    check_val({tag, ".idle_ack"},  32'(ack_of(s)), 32'd0);
    check_val({tag, ".idle_busy"}, 32'(busy_of(s)), 32'd0);
  endtask

  initial begin
    int t, t1, t2;
    logic [31:0] a, b, r1;
    rst = 1'b1; req4 = 1'b0; req1 = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    exp_rd[0] = '0; exp_rd[1] = '0;

    // Reset check
    repeat (3) @(posedge clk);
    #1;
    check_val("rst.ack4", 32'(ack4), 0);   check_val("rst.err4", 32'(err4), 0);
    check_val("rst.busy4", 32'(busy4), 0); check_val("rst.rdata4", rdata4, 0);
    check_val("rst.ack1", 32'(ack1), 0);   check_val("rst.busy1", 32'(busy1), 0);
    check_val("rst.rdata1", rdata1, 0);
    @(negedge clk); rst = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      check_val("post_rst.busy4", 32'(busy4), 0);
      check_val("post_rst.ack4", 32'(ack4), 0);
    end

    // Fill both arrays so every word has a known value.
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 256; i++)
        access(s, 1'b1, 32'(i) << 2, $urandom, 1'b0, "fill");

    // Store then load
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, "st10");
    access(0, 1'b0, 32'h10, 32'h0, 1'b0, "ld10");
    check_val("ld10.value", rdata4, 32'hDEADBEEF);

    // Rejected accesses and the top boundary
    access(0, 1'b1, 32'h12, 32'h55AA55AA, 1'b0, "st_mis");
    access(0, 1'b0, 32'h10, 32'h0, 1'b0, "ld10_again");
    check_val("ld10_again.value", rdata4, 32'hDEADBEEF);
    access(0, 1'b0, 32'h400, 32'h0, 1'b0, "ld_oor");
    access(0, 1'b1, 32'h3FC, 32'h0BADF00D, 1'b0, "st_top");
    access(0, 1'b0, 32'h3FC, 32'h0, 1'b0, "ld_top");
    check_val("ld_top.value", rdata4, 32'h0BADF00D);

    // Reset mid-store
    access(0, 1'b1, 32'h20, 32'hCAFEF00D, 1'b0, "preload20");
    @(negedge clk);
    we = 1'b1; addr = 32'h20; wdata = 32'h12345678; req4 = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    check_val("abort.busy_before", 32'(busy4), 1);
    rst = 1'b1; req4 = 1'b0;
    #1;
    check_val("abort.busy_now", 32'(busy4), 0);
    exp_rd[0] = '0; exp_rd[1] = '0;
    repeat (6) begin
      @(posedge clk); #1;
      check_val("abort.no_ack", 32'(ack4), 0);
    end
    check_val("abort.rdata_reset", rdata4, 0);
    @(negedge clk); rst = 1'b0;
    access(0, 1'b0, 32'h20, 32'h0, 1'b0, "ld20_after_abort");
    check_val("ld20.value", rdata4, 32'hCAFEF00D);

    // Back-to-back loads on the LATENCY=1 instance
    a = 32'h44; b = 32'h3F0;
    @(negedge clk);
    we = 1'b0; addr = a; req1 = 1'b1;
    t = 0; t1 = -1; t2 = -1; r1 = '0;
    while (t2 < 0 && t < 40) begin
      @(posedge clk); #1; t++;
      if (ack1 && t1 < 0) begin
        t1 = t; r1 = rdata1; addr = b;
      end else if (ack1) begin
        t2 = t;
        req1 = 1'b0;
      end else if (t1 >= 0 && t == t1 + 1) begin
        check_val("b2b.gap_busy", 32'(busy1), 0);
      end
    end
    check_val("b2b.first_data", r1, mem_m[1][a[9:2]]);
    check_val("b2b.spacing", 32'(t2 - t1), 32'd3);
    check_val("b2b.second_data", rdata1, mem_m[1][b[9:2]]);
    exp_rd[1] = mem_m[1][b[9:2]];
    @(posedge clk); #1;
    check_val("b2b.idle", 32'(busy1), 0);

    // Input disturbance during WAIT
    access(0, 1'b1, 32'h84, 32'h600DCAFE, 1'b1, "st_disturb");
    access(0, 1'b0, 32'h84, 32'h0, 1'b0, "ld_disturb");
    check_val("ld_disturb.value", rdata4, 32'h600DCAFE);
    access(1, 1'b0, 32'h8, 32'h0, 1'b1, "ld1_disturb");

    // Random traffic on both instances
    for (int i = 0; i < 80; i++) begin
      logic [31:0] ra;
      case ($urandom_range(0, 5))
        1: ra = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
        2: ra = ($urandom | 32'h400) & ~32'h3;
        3: ra = 32'h3FC;
        4: ra = 32'h400;
        default: ra = 32'($urandom_range(0, 255)) << 2;
      endcase
      access(i % 2, 1'($urandom), ra, $urandom, 1'($urandom_range(0, 3) == 0), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
